mandel_engine_scheduler: RTL
============================

// Module: mandel_engine_scheduler
// PURPOSE
// Frame-level scheduler for a bank of N_ENGINES Mandelbrot depth engines.
// - Walks the screen in raster order and computes c = (re_c, im_c) incrementally per pixel.
// - Dispatches pixels to engines in strict round-robin order and holds each engine's c stable while it iterates.
// - Retires results in the same round-robin order, so the pixel stream leaves in raster order on a valid/ready port.
// - Sits between the frame/config registers and the pixel-colour/framebuffer path.
// PARAMETERS
// N_ENGINES    4    number of depth engines; >=1
// WORD_LENGTH  32   fixed-point word width of c
// FRAC         28   fractional bits of c; informational only, no scaling done here
// WIDTH        640  pixels per line; <=1024
// HEIGHT       480  lines per frame; <=512
// PORTS
// sysclk        in   1                  clock
// reset         in   1                  sync active-high reset
// frame_start   in   1                  pulse: begin a frame; honoured only in IDLE
// cfg_re_start  in   WORD_LENGTH        signed re(c) at x=0
// cfg_im_start  in   WORD_LENGTH        signed im(c) at y=0
// cfg_re_step   in   WORD_LENGTH        signed re increment per x
// cfg_im_step   in   WORD_LENGTH        signed im increment per y
// cfg_max_iter  in   10                 iteration limit
// frame_busy    out  1                  high when not IDLE
// frame_done    out  1                  1-cycle pulse: last pixel retired
// eng_start     out  N_ENGINES          per-engine 1-cycle start pulse
// eng_re_c      out  N_ENGINES*WORD_LENGTH  per-engine c, held while engine busy
// eng_im_c      out  N_ENGINES*WORD_LENGTH
// eng_max_iter  out  10                 latched cfg_max_iter, to all engines
// eng_done      in   N_ENGINES          engine result-ready level
// eng_depth     in   N_ENGINES*10       engine final depth
// pix_valid     out  1                  result available
// pix_ready     in   1                  consumer accepts
// pix_x         out  10                 pixel column
// pix_y         out  9                  pixel row
// pix_depth     out  10                 iteration count
// pix_eol       out  1                  pix_x == WIDTH-1
// pix_eof       out  1                  last pixel of frame
// BEHAVIOUR
// - Reset: state=IDLE; all slots FREE; pointers d=r=0; x=y=0.
//   All outputs 0: frame_busy, frame_done, eng_start, eng_re_c, eng_im_c, eng_max_iter, pix_*.
//   Reset mid-frame abandons the frame with no frame_done; engines share the same reset.
// - FSM IDLE->RUN on frame_start.
//   On that edge: latch all cfg_*; x=y=0; re_acc=cfg_re_start; im_acc=cfg_im_start.
// - FSM RUN->DRAIN on the edge that dispatches (WIDTH-1, HEIGHT-1).
// - FSM DRAIN->IDLE on the edge that retires the eof pixel; frame_done=1 for exactly the following cycle.
// - frame_start in RUN or DRAIN is ignored.
// - Per-engine slot state: FREE, BUSY, RESULT; each slot holds x/y tag, c and depth.
// - Dispatch (RUN only, at most 1 per cycle), when slot[d]==FREE:
//   - eng_start[d]=1 for the next cycle only; eng_re_c[d]=re_acc, eng_im_c[d]=im_acc.
//   - Slot becomes BUSY with tag (x,y); d=(d+1) mod N_ENGINES.
//   - Raster advance: x++, re_acc+=re_step.
//   - At x==WIDTH-1: x=0, y++, re_acc=re_start, im_acc+=im_step.
// - Accumulator arithmetic: WORD_LENGTH two's-complement, wraps silently.
// - eng_re_c[i] / eng_im_c[i] are unchanged from dispatch until the slot returns to FREE.
// - Completion: BUSY & eng_done[i] & ~eng_start[i] -> RESULT; capture eng_depth[i].
//   eng_done is ignored while eng_start[i] is high, because a stale done from the previous pixel is still asserted then.
// - Retire: pix_valid = (slot[r]==RESULT); pix_x/pix_y/pix_depth/pix_eol/pix_eof are muxed from slot[r].
//   - pix_* stay stable while pix_valid & ~pix_ready.
//   - On valid&ready: slot FREE, r=(r+1) mod N_ENGINES.
// - A slot freed on edge k can be re-dispatched no earlier than edge k+1.
//   Completion and dispatch on different slots in the same cycle are independent.
// - Order guarantee: the retire sequence equals the dispatch sequence (raster order).
//   If pix_ready is low, dispatch stalls once every slot is BUSY or RESULT.
// - Latency: first eng_start is high 2 cycles after the frame_start cycle.
// - N_ENGINES=1 degenerates to serial operation and must work.
// TESTING
// - N=2, WIDTH=4, HEIGHT=2, re_start=0xE0000000, re_step=0x08000000, im_start=0xF0000000, im_step=0x10000000:
//   eng_re_c sequence E0000000,E8000000,F0000000,F8000000, repeated on row 1; im_c F0000000 on row 0, 00000000 on row 1.
// - Engine models with unequal latencies (engine1 finishes first) -> pix_x/pix_y still emitted in raster order 0..7.
//   pix_eol on x=3; pix_eof only on (3,1); frame_done 1 cycle after the eof handshake.
// - pix_ready held low for 50 cycles -> exactly N_ENGINES eng_start pulses, then stall, pix_* stable.
//   On release, all 8 pixels are delivered, none lost or duplicated.
// - frame_start pulsed during RUN -> no effect.
//   frame_start in IDLE after frame_done -> new frame restarts at (0,0) with newly latched cfg.
// - Reset asserted mid-RUN -> next cycle all outputs 0, state IDLE, no frame_done.
//   A subsequent frame_start runs a clean frame.
// - eng_done left high from the previous pixel when a slot is re-dispatched -> not accepted as a completion during the eng_start cycle.

Source files
------------

// File: rtl/mandel_engine_scheduler_if.sv
// Pixel result stream leaving the Mandelbrot scheduler.
// Valid/ready handshake; payload holds while stalled.
interface mandel_engine_scheduler_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [9:0] pix_depth;
  logic       pix_eol;
  logic       pix_eof;

  modport master (
    output pix_valid, pix_x, pix_y, pix_depth,
    output pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_depth,
    input  pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/mandel_engine_scheduler.sv
// Mandelbrot engine-bank scheduler: raster walk of c, round-robin
// dispatch to depth engines, in-order retirement of pixel results.
module mandel_engine_scheduler #(
  parameter int N_ENGINES   = 4,
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic [WORD_LENGTH-1:0]           cfg_re_start,
  input  logic [WORD_LENGTH-1:0]           cfg_im_start,
  input  logic [WORD_LENGTH-1:0]           cfg_re_step,
  input  logic [WORD_LENGTH-1:0]           cfg_im_step,
  input  logic [9:0]                       cfg_max_iter,
  output logic                             frame_busy,
  output logic                             frame_done,
  output logic [N_ENGINES-1:0]             eng_start,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_re_c,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_im_c,
  output logic [9:0]                       eng_max_iter,
  input  logic [N_ENGINES-1:0]             eng_done,
  input  logic [N_ENGINES*10-1:0]          eng_depth,
  mandel_engine_scheduler_if.master        pix
);
  localparam int WL = WORD_LENGTH;
  localparam int PW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(N_ENGINES - 1);
  localparam logic [9:0]    LAST_X = 10'(WIDTH - 1);
  localparam logic [8:0]    LAST_Y = 9'(HEIGHT - 1);

  if (FRAC >= WORD_LENGTH || N_ENGINES < 1) begin : g_bad_param
    $error("mandel_engine_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  typedef enum logic [1:0] {FREE, BUSY, RESULT} slot_e;

  state_e          state_q;
  slot_e           slot_q   [N_ENGINES];
  logic [WL-1:0]   re_c_q   [N_ENGINES];
  logic [WL-1:0]   im_c_q   [N_ENGINES];
  logic [9:0]      tx_q     [N_ENGINES];
  logic [8:0]      ty_q     [N_ENGINES];
  logic [9:0]      dep_q    [N_ENGINES];
  logic [PW-1:0]   d_q, r_q;
  logic [9:0]      x_q;
  logic [8:0]      y_q;
  logic [WL-1:0]   re_acc_q, im_acc_q;
  logic [WL-1:0]   re_start_q, re_step_q, im_step_q;
  logic [9:0]      max_iter_q;
  logic [N_ENGINES-1:0] start_q;
  logic            done_q;

  logic dispatch, retire, last_x, last_px;
  logic rd_valid, rd_eol, rd_eof;

  function automatic logic [PW-1:0] inc_p(logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign last_x   = (x_q == LAST_X);
  assign last_px  = last_x && (y_q == LAST_Y);
  assign dispatch = (state_q == S_RUN) && (slot_q[d_q] == FREE);
  assign rd_valid = (slot_q[r_q] == RESULT);
  assign rd_eol   = (tx_q[r_q] == LAST_X);
  assign rd_eof   = rd_eol && (ty_q[r_q] == LAST_Y);
  assign retire   = rd_valid && pix.pix_ready;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      r_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      re_acc_q   <= '0;
      im_acc_q   <= '0;
      re_start_q <= '0;
      re_step_q  <= '0;
      im_step_q  <= '0;
      max_iter_q <= '0;
      start_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < N_ENGINES; i++) begin
        slot_q[i] <= FREE;
        re_c_q[i] <= '0;
        im_c_q[i] <= '0;
        tx_q[i]   <= '0;
        ty_q[i]   <= '0;
        dep_q[i]  <= '0;
      end
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      // a done seen in the start cycle belongs to the previous pixel
      for (int i = 0; i < N_ENGINES; i++) begin
        if (slot_q[i] == BUSY && eng_done[i] && !start_q[i]) begin
          slot_q[i] <= RESULT;
          dep_q[i]  <= eng_depth[i*10 +: 10];
        end
      end
      if (retire) begin
        slot_q[r_q] <= FREE;
        r_q         <= inc_p(r_q);
      end
      if (dispatch) begin
        slot_q[d_q]  <= BUSY;
        start_q[d_q] <= 1'b1;
        re_c_q[d_q]  <= re_acc_q;
        im_c_q[d_q]  <= im_acc_q;
        tx_q[d_q]    <= x_q;
        ty_q[d_q]    <= y_q;
        d_q          <= inc_p(d_q);
        if (last_x) begin
          x_q      <= '0;
          y_q      <= y_q + 1'b1;
          re_acc_q <= re_start_q;
          im_acc_q <= im_acc_q + im_step_q;
        end else begin
          x_q      <= x_q + 1'b1;
          re_acc_q <= re_acc_q + re_step_q;
        end
      end
      unique case (state_q)
        S_IDLE: if (frame_start) begin
          state_q    <= S_RUN;
          x_q        <= '0;
          y_q        <= '0;
          re_acc_q   <= cfg_re_start;
          im_acc_q   <= cfg_im_start;
          re_start_q <= cfg_re_start;
          re_step_q  <= cfg_re_step;
          im_step_q  <= cfg_im_step;
          max_iter_q <= cfg_max_iter;
        end
        S_RUN: if (dispatch && last_px) state_q <= S_DRAIN;
        S_DRAIN: if (retire && rd_eof) begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_ENGINES; g++) begin : g_eng
    assign eng_re_c[g*WL +: WL] = re_c_q[g];
    assign eng_im_c[g*WL +: WL] = im_c_q[g];
  end

  assign eng_start     = start_q;
  assign eng_max_iter  = max_iter_q;
  assign frame_busy    = (state_q != S_IDLE);
  assign frame_done    = done_q;
  assign pix.pix_valid = rd_valid;
  assign pix.pix_x     = tx_q[r_q];
  assign pix.pix_y     = ty_q[r_q];
  assign pix.pix_depth = dep_q[r_q];
  assign pix.pix_eol   = rd_eol;
  assign pix.pix_eof   = rd_eof;
endmodule
